// File: rtl/noc_flit_buffer.sv
// First-word-fall-through flit buffer for NoC router input ports.
// Provides a valid/ready handshake on both sides, occupancy flags and a synchronous flush.
module noc_flit_buffer #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned AF_LEVEL = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       wr_valid_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    output logic                       wr_ready_o,
    output logic                       rd_valid_o,
    output logic [WIDTH-1:0]           rd_data_o,
    input  logic                       rd_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       almost_full_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    localparam logic [PW-1:0] LastPtr  = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);
    localparam logic [CW-1:0] AfCnt    = CW'(AF_LEVEL);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop;

    // Status and handshake outputs depend only on registered state.
    assign count_o       = count_q;
    assign full_o        = (count_q == DepthCnt);
    assign empty_o       = (count_q == '0);
    assign almost_full_o = (count_q >= AfCnt);
    assign wr_ready_o    = !full_o;
    assign rd_valid_o    = !empty_o;
    assign rd_data_o     = mem_q[rd_ptr_q];

    assign push = wr_valid_i & wr_ready_o;
    assign pop  = rd_valid_o & rd_ready_i;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wr_data_i;
                wr_ptr_d        = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
